// File: rtl/mem_arbiter_if.sv
// Request/response bundle between the pipeline, mem_arbiter and the memory array.
// The arbiter uses the slave modport; the pipeline/memory environment uses master.
interface mem_arbiter_if #(
  parameter int unsigned AW = 16,
  parameter int unsigned DW = 16
);
  // Instruction fetch side
  logic          if_req;
  logic [AW-1:0] if_addr;
  logic          if_flush;
  logic [DW-1:0] if_rdata;
  logic          if_done;
  logic          stall_if;

  // Data side
  logic          d_rd;
  logic          d_wr;
  logic [AW-1:0] d_addr;
  logic [DW-1:0] d_wdata;
  logic [DW-1:0] d_rdata;
  logic          d_done;
  logic          stall_mem;

  // Memory side
  logic          mem_en;
  logic          mem_wr;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic [DW-1:0] mem_rdata;

  // Status
  logic          busy;
  logic          err;

  modport slave (
    input  if_req, if_addr, if_flush,
    input  d_rd, d_wr, d_addr, d_wdata,
    input  mem_rdata,
    output if_rdata, if_done, stall_if,
    output d_rdata, d_done, stall_mem,
    output mem_en, mem_wr, mem_addr, mem_wdata,
    output busy, err
  );

  modport master (
    output if_req, if_addr, if_flush,
    output d_rd, d_wr, d_addr, d_wdata,
    output mem_rdata,
    input  if_rdata, if_done, stall_if,
    input  d_rdata, d_done, stall_mem,
    input  mem_en, mem_wr, mem_addr, mem_wdata,
    input  busy, err
  );
endinterface

// File: rtl/mem_arbiter.sv
// Single-port memory arbiter between instruction fetch and data access (IDLE->ACCESS->DONE).
// Define MEM_ARB_RR_EN for round-robin arbitration; otherwise data has fixed priority.
module mem_arbiter #(
  parameter int unsigned MEM_LAT = 2,
  parameter int unsigned AW      = 16,
  parameter int unsigned DW      = 16
) (
  input logic          clk,
  input logic          rst,
  mem_arbiter_if.slave bus
);

  localparam int unsigned    CntW    = (MEM_LAT > 1) ? $clog2(MEM_LAT) : 1;
  localparam logic [CntW-1:0] CntLoad = CntW'(MEM_LAT - 1);

  typedef enum logic [1:0] {
    StIdle   = 2'd0,
    StAccess = 2'd1,
    StDone   = 2'd2
  } state_e;

  state_e          state_q, state_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic            port_data_q, port_data_d;
  logic [AW-1:0]   addr_q, addr_d;
  logic [DW-1:0]   wdata_q, wdata_d;
  logic            wr_q, wr_d;
  logic [DW-1:0]   fetch_buf_q, fetch_buf_d;
  logic            flush_q, flush_d;
  logic [DW-1:0]   if_rdata_q, if_rdata_d;
  logic [DW-1:0]   d_rdata_q, d_rdata_d;
  logic            err_q, err_d;

  logic            d_req;
  logic            grant_any;
  logic            grant_data;
  logic            fetch_ok;
  logic            d_done;
  logic            if_done;

  assign d_req     = bus.d_rd | bus.d_wr;
  assign grant_any = d_req | bus.if_req;

`ifdef MEM_ARB_RR_EN
  // last_data_q: 1 when the most recent grant went to the data port.
  logic last_data_q, last_data_d;

  assign grant_data = d_req & ~(bus.if_req & last_data_q);

  always_comb begin
    last_data_d = last_data_q;
    if (state_q == StIdle && grant_any) begin
      last_data_d = grant_data;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      last_data_q <= 1'b1;
    end else begin
      last_data_q <= last_data_d;
    end
  end
`else
  assign grant_data = d_req;
`endif

  // State register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:   if (grant_any) state_d = StAccess;
      StAccess: if (cnt_q == '0) state_d = StDone;
      StDone:   state_d = StIdle;
      default:  state_d = StIdle;
    endcase
  end

  // A flush seen in any ACCESS cycle, or live during DONE, cancels the fetch result.
  assign fetch_ok = (state_q == StDone) & ~port_data_q & ~flush_q & ~bus.if_flush;

  // Datapath next-state
  always_comb begin
    cnt_d       = cnt_q;
    port_data_d = port_data_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    wr_d        = wr_q;
    fetch_buf_d = fetch_buf_q;
    flush_d     = flush_q;
    if_rdata_d  = if_rdata_q;
    d_rdata_d   = d_rdata_q;
    err_d       = err_q;
    unique case (state_q)
      StIdle: begin
        if (grant_any) begin
          port_data_d = grant_data;
          addr_d      = grant_data ? bus.d_addr : bus.if_addr;
          wdata_d     = grant_data ? bus.d_wdata : '0;
          // Simultaneous read and write resolves to a write and flags the error.
          wr_d        = grant_data & bus.d_wr;
          err_d       = err_q | (grant_data & bus.d_rd & bus.d_wr);
          cnt_d       = CntLoad;
          flush_d     = 1'b0;
        end
      end
      StAccess: begin
        flush_d = flush_q | (~port_data_q & bus.if_flush);
        if (cnt_q == '0) begin
          if (!wr_q) begin
            if (port_data_q) begin
              d_rdata_d = bus.mem_rdata;
            end else begin
              fetch_buf_d = bus.mem_rdata;
            end
          end
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      StDone: begin
        if (fetch_ok) begin
          if_rdata_d = fetch_buf_q;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_q       <= '0;
      port_data_q <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= '0;
      wr_q        <= 1'b0;
      fetch_buf_q <= '0;
      flush_q     <= 1'b0;
      if_rdata_q  <= '0;
      d_rdata_q   <= '0;
      err_q       <= 1'b0;
    end else begin
      cnt_q       <= cnt_d;
      port_data_q <= port_data_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      wr_q        <= wr_d;
      fetch_buf_q <= fetch_buf_d;
      flush_q     <= flush_d;
      if_rdata_q  <= if_rdata_d;
      d_rdata_q   <= d_rdata_d;
      err_q       <= err_d;
    end
  end

  // Output logic
  always_comb begin
    d_done         = (state_q == StDone) & port_data_q;
    if_done        = fetch_ok;
    bus.d_done     = d_done;
    bus.if_done    = if_done;
    bus.mem_en     = (state_q == StAccess);
    bus.mem_wr     = (state_q == StAccess) & wr_q;
    bus.mem_addr   = addr_q;
    bus.mem_wdata  = wdata_q;
    bus.busy       = (state_q != StIdle);
    bus.err        = err_q;
    bus.d_rdata    = d_rdata_q;
    // Fetched word is presented alongside if_done, then held in if_rdata_q.
    bus.if_rdata   = fetch_ok ? fetch_buf_q : if_rdata_q;
    bus.stall_mem  = d_req & ~d_done;
    bus.stall_if   = bus.if_req & ~if_done;
  end

endmodule
